// File: rtl/alu_muldiv_seq.sv
// Sequential EXE-stage ALU: registered single-cycle ops plus an iterative multiply/divide unit driving HI/LO.
// Optional build macro ALU_DIV_EN adds the restoring divider; without it DIV/DIVU behave as NOP.
module alu_muldiv_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   val1,
    input  logic [WIDTH-1:0]   val2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   aluout,
    output logic               out_valid,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, next_state;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] cnt;
    logic               is_mul, neg_lo, neg_hi;

    logic               alu_load, mul_load, div_load, dz_load;
    logic [WIDTH-1:0]   alu_result;
    logic               op_signed, sign_diff;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   rem, quo, fin_hi, fin_lo;

    // acc = {partial product, remaining multiplier bits}; one multiplier bit retired per call
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc_in,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {sum, acc_in[WIDTH-1:1]};
    endfunction

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc_in,
                                                    input logic [WIDTH-1:0]   divisor);
        logic [WIDTH:0] shifted, diff;
        shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[WIDTH])
            return {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        else
            return {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
    endfunction

    assign op_signed = (op == 4'd12) || (op == 4'd14);
    assign sign_diff = val1[WIDTH-1] ^ val2[WIDTH-1];
    assign mag_a     = (op_signed && val1[WIDTH-1]) ? -val1 : val1;
    assign mag_b     = (op_signed && val2[WIDTH-1]) ? -val2 : val2;

    always_comb begin
        alu_result = '0;
        case (op)
            4'd0:    alu_result = val1 + val2;
            4'd1:    alu_result = val1 & val2;
            4'd2:    alu_result = val1 - val2;
            4'd3:    alu_result = val1 | val2;
            4'd4:    alu_result = {{(WIDTH-1){1'b0}}, $signed(val1) < $signed(val2)};
            4'd5:    alu_result = ~(val1 | val2);
            4'd6:    alu_result = val2 << shamt;
            4'd7:    alu_result = val2 >> shamt;
            4'd9:    alu_result = WIDTH'($signed(val2) >>> shamt);
            4'd10:   alu_result = {{(WIDTH-1){1'b0}}, val1 < val2};
            4'd11:   alu_result = val1 ^ val2;
            default: alu_result = '0;
        endcase
    end

    // Signed results are rebuilt from magnitudes when DONE commits them
    assign product = neg_lo ? -acc : acc;
    assign rem     = acc[2*WIDTH-1:WIDTH];
    assign quo     = acc[WIDTH-1:0];
    assign fin_hi  = is_mul ? product[2*WIDTH-1:WIDTH] : (neg_hi ? -rem : rem);
    assign fin_lo  = is_mul ? product[WIDTH-1:0]       : (neg_lo ? -quo : quo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    always_comb begin
        next_state = state;
        alu_load   = 1'b0;
        mul_load   = 1'b0;
        div_load   = 1'b0;
        dz_load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == 4'd12 || op == 4'd13) begin
                        mul_load   = 1'b1;
                        next_state = MUL;
                    end
`ifdef ALU_DIV_EN
                    else if (op == 4'd14 || op == 4'd15) begin
                        if (val2 == '0) begin
                            dz_load    = 1'b1;
                            next_state = DONE;
                        end else begin
                            div_load   = 1'b1;
                            next_state = DIV;
                        end
                    end
`endif
                    else begin
                        alu_load = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt == LAST_ITER)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The first iteration runs on the load edge so DONE lands inside the WIDTH busy cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            aluout    <= '0;
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            acc       <= '0;
            operand   <= '0;
            cnt       <= '0;
            is_mul    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (alu_load) begin
                aluout    <= alu_result;
                out_valid <= 1'b1;
            end
            if (mul_load) begin
                acc     <= mul_step({{WIDTH{1'b0}}, mag_b}, mag_a);
                operand <= mag_a;
                cnt     <= SHAMT_W'(1);
                is_mul  <= 1'b1;
                neg_lo  <= op_signed & sign_diff;
                neg_hi  <= 1'b0;
            end
            if (div_load) begin
                acc     <= div_step({{WIDTH{1'b0}}, mag_a}, mag_b);
                operand <= mag_b;
                cnt     <= SHAMT_W'(1);
                is_mul  <= 1'b0;
                neg_lo  <= op_signed & sign_diff;
                neg_hi  <= op_signed & val1[WIDTH-1];
            end
            if (dz_load) begin
                acc    <= {val1, {WIDTH{1'b1}}};
                is_mul <= 1'b0;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
            end
            case (state)
                MUL: begin
                    acc <= mul_step(acc, operand);
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= div_step(acc, operand);
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    hi        <= fin_hi;
                    lo        <= fin_lo;
                    aluout    <= fin_lo;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
